// File: rtl/sim_mon_pkg.sv
// Shared types and default widths for the simulation status monitor.
package sim_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam int DEF_PC_W  = 32;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_HIT_N = 2;

endpackage

// File: rtl/target_matcher.sv
// Counts consecutive valid PC samples equal to a target address; stalls hold the streak.
module target_matcher #(
    parameter int PC_W  = 32,
    parameter int HIT_N = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_en,
    input  logic                         i_pc_valid,
    input  logic [PC_W-1:0]              i_pc,
    input  logic [PC_W-1:0]              i_target,
    output logic                         o_hit,
    output logic [$clog2(HIT_N+1)-1:0]   o_cnt
);

    localparam int CW = $clog2(HIT_N + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(HIT_N);
    localparam logic [CW-1:0] CNT_LAST = CW'(HIT_N - 1);

    logic          w_match;
    logic [CW-1:0] r_cnt;

    assign w_match = (i_pc == i_target);

    // Streak counter: cleared on arm, bumps on a valid match, drops on a valid miss.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && i_pc_valid) begin
            if (!w_match) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // The current sample completes the streak when it is the HIT_N-th consecutive match.
    always_comb begin
        o_hit = i_en & i_pc_valid & w_match & (r_cnt == CNT_LAST);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sim_status_monitor.sv
// Pass/fail/timeout monitor watching the IF/ID PC stream of a core under test.
module sim_status_monitor
    import sim_mon_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int HIT_N = DEF_HIT_N
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pc_valid,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [PC_W-1:0]   i_pass_pc,
    input  logic [PC_W-1:0]   i_fail_pc,
    input  logic [CNT_W-1:0]  i_timeout_cycles,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_fail,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic [PC_W-1:0]   o_final_pc
);

    localparam int CW = $clog2(HIT_N + 1);

    state_e          r_state;
    state_e          w_next;
    logic            w_run;
    logic            w_arm;
    logic            w_pass_hit;
    logic            w_fail_hit;
    logic            w_tmo_hit;
    logic [CW-1:0]   w_pass_cnt;
    logic [CW-1:0]   w_fail_cnt;
    logic [CNT_W:0]  w_cnt_next;
    logic [CNT_W-1:0] r_cycle;
    logic [PC_W-1:0] r_final_pc;

    assign w_run = (r_state == ST_RUN);
    assign w_arm = i_start & (r_state != ST_RUN);

    target_matcher #(.PC_W(PC_W), .HIT_N(HIT_N)) u_pass_match (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_arm),
        .i_en       (w_run),
        .i_pc_valid (i_pc_valid),
        .i_pc       (i_pc),
        .i_target   (i_pass_pc),
        .o_hit      (w_pass_hit),
        .o_cnt      (w_pass_cnt)
    );

    target_matcher #(.PC_W(PC_W), .HIT_N(HIT_N)) u_fail_match (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_arm),
        .i_en       (w_run),
        .i_pc_valid (i_pc_valid),
        .i_pc       (i_pc),
        .i_target   (i_fail_pc),
        .o_hit      (w_fail_hit),
        .o_cnt      (w_fail_cnt)
    );

    // Watchdog fires when this RUN cycle would be the timeout_cycles-th one; the extra bit avoids wrap.
    always_comb begin
        w_cnt_next = {1'b0, r_cycle} + 1'b1;
        w_tmo_hit  = (i_timeout_cycles != '0) && (w_cnt_next == {1'b0, i_timeout_cycles});
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: fail outranks pass, and any hit outranks the watchdog.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_fail_hit)      w_next = ST_FAIL;
                else if (w_pass_hit) w_next = ST_PASS;
                else if (w_tmo_hit)  w_next = ST_TIMEOUT;
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (i_start) w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Status flags decoded straight from the registered state.
    always_comb begin
        o_busy    = (r_state == ST_RUN);
        o_pass    = (r_state == ST_PASS);
        o_fail    = (r_state == ST_FAIL);
        o_timeout = (r_state == ST_TIMEOUT);
        o_done    = o_pass | o_fail | o_timeout;
    end

    // Cycle counter: cleared on arm, counts every RUN cycle including the exiting one, saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle <= '0;
        end else if (w_arm) begin
            r_cycle <= '0;
        end else if (w_run && (r_cycle != '1)) begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Final PC captures the completing sample; a timeout leaves the cleared zero in place.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_final_pc <= '0;
        end else if (w_arm) begin
            r_final_pc <= '0;
        end else if (w_run && (w_fail_hit || w_pass_hit)) begin
            r_final_pc <= i_pc;
        end
    end

    assign o_cycle_count = r_cycle;
    assign o_final_pc    = r_final_pc;

endmodule

// File: tb/tb_sim_status_monitor.sv
// Self-checking bench for sim_status_monitor: per-cycle vector table plus hand sequences.
module tb_sim_status_monitor;

    typedef struct {
        string       name;
        logic        start;
        logic        valid;
        logic [31:0] pc;
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [31:0] cyc;
        logic [31:0] fpc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pcValid;
    logic [31:0] pc;
    logic [31:0] passPc;
    logic [31:0] failPc;
    logic [31:0] timeoutCycles;

    logic        busy0, done0, pass0, fail0, tmo0;
    logic [31:0] cyc0, fpc0;
    logic        busy1, done1, pass1, fail1, tmo1;
    logic [31:0] cyc1, fpc1;

    int vecCount  = 0;
    int missCount = 0;

    vec_t tbl[$];
    vec_t expQ[$];

    sim_status_monitor #(.PC_W(32), .CNT_W(32), .HIT_N(2)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_pc_valid       (pcValid),
        .i_pc             (pc),
        .i_pass_pc        (passPc),
        .i_fail_pc        (failPc),
        .i_timeout_cycles (timeoutCycles),
        .o_busy           (busy0),
        .o_done           (done0),
        .o_pass           (pass0),
        .o_fail           (fail0),
        .o_timeout        (tmo0),
        .o_cycle_count    (cyc0),
        .o_final_pc       (fpc0)
    );

    sim_status_monitor #(.PC_W(32), .CNT_W(32), .HIT_N(1)) dutHit1 (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_pc_valid       (pcValid),
        .i_pc             (pc),
        .i_pass_pc        (passPc),
        .i_fail_pc        (failPc),
        .i_timeout_cycles (timeoutCycles),
        .o_busy           (busy1),
        .o_done           (done1),
        .o_pass           (pass1),
        .o_fail           (fail1),
        .o_timeout        (tmo1),
        .o_cycle_count    (cyc1),
        .o_final_pc       (fpc1)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string name, logic st, logic v, logic [31:0] p,
                                logic b, logic ps, logic fl, logic to,
                                logic [31:0] cyc, logic [31:0] fpc);
        vec_t r;
        r.name  = name;
        r.start = st;
        r.valid = v;
        r.pc    = p;
        r.busy  = b;
        r.pass  = ps;
        r.fail  = fl;
        r.tmo   = to;
        r.done  = ps | fl | to;
        r.cyc   = cyc;
        r.fpc   = fpc;
        return r;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        start   = v.start;
        pcValid = v.valid;
        pc      = v.pc;
        expQ.push_back(v);
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expectation and compare it with the main DUT
    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL scoreboard: queue empty, expected an entry");
            return;
        end
        e = expQ.pop_front();
        vecCount++;
        if (busy0 !== e.busy || done0 !== e.done || pass0 !== e.pass || fail0 !== e.fail ||
            tmo0 !== e.tmo || cyc0 !== e.cyc || fpc0 !== e.fpc) begin
            missCount++;
            $display("[TB] FAIL %s: got busy/done/pass/fail/tmo=%b%b%b%b%b cyc=%0d fpc=%h, expected %b%b%b%b%b cyc=%0d fpc=%h",
                     e.name, busy0, done0, pass0, fail0, tmo0, cyc0, fpc0,
                     e.busy, e.done, e.pass, e.fail, e.tmo, e.cyc, e.fpc);
        end
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    task automatic checkHit1(input string name, input logic b, input logic ps, input logic fl,
                             input logic [31:0] cyc, input logic [31:0] fpc);
        vecCount++;
        if (busy1 !== b || pass1 !== ps || fail1 !== fl || tmo1 !== 1'b0 ||
            done1 !== (ps | fl) || cyc1 !== cyc || fpc1 !== fpc) begin
            missCount++;
            $display("[TB] FAIL %s: got busy/pass/fail/tmo=%b%b%b%b cyc=%0d fpc=%h, expected %b%b%b0 cyc=%0d fpc=%h",
                     name, busy1, pass1, fail1, tmo1, cyc1, fpc1, b, ps, fl, cyc, fpc);
        end
    endtask

    task automatic checkAllZero(input string name);
        vecCount++;
        if ({busy0, done0, pass0, fail0, tmo0} !== 5'b0 || cyc0 !== 32'd0 || fpc0 !== 32'd0 ||
            {busy1, done1, pass1, fail1, tmo1} !== 5'b0 || cyc1 !== 32'd0 || fpc1 !== 32'd0) begin
            missCount++;
            $display("[TB] FAIL %s: got flags=%b%b%b%b%b cyc=%0d fpc=%h, expected all zero",
                     name, busy0, done0, pass0, fail0, tmo0, cyc0, fpc0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        pcValid       = 1'b0;
        pc            = 32'h0;
        passPc        = 32'h5F0;
        failPc        = 32'h5DC;
        timeoutCycles = 32'd0;

        // Basic pass, sticky terminal state, re-arm and identical repeat
        tbl.push_back(mk("arm",        1, 0, 32'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("run_100",    0, 1, 32'h100, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("run_104",    0, 1, 32'h104, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("first_5f0",  0, 1, 32'h5F0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("pass",       0, 1, 32'h5F0, 0, 1, 0, 0, 4, 32'h5F0));
        tbl.push_back(mk("pass_held",  0, 1, 32'h100, 0, 1, 0, 0, 4, 32'h5F0));
        tbl.push_back(mk("rearm",      1, 0, 32'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rep_100",    0, 1, 32'h100, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("rep_104",    0, 1, 32'h104, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("rep_5f0",    0, 1, 32'h5F0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("rep_pass",   0, 1, 32'h5F0, 0, 1, 0, 0, 4, 32'h5F0));
        // Stall keeps the streak alive
        tbl.push_back(mk("stall_arm",  1, 0, 32'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("stall_5f0",  0, 1, 32'h5F0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("stall_bub",  0, 0, 32'h123, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("stall_pass", 0, 1, 32'h5F0, 0, 1, 0, 0, 3, 32'h5F0));
        // Mismatch breaks the streak; start inside RUN is ignored
        tbl.push_back(mk("brk_arm",    1, 0, 32'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("brk_5f0",    0, 1, 32'h5F0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("brk_5f4",    1, 1, 32'h5F4, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("brk_5f0b",   0, 1, 32'h5F0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("brk_pass",   0, 1, 32'h5F0, 0, 1, 0, 0, 4, 32'h5F0));
        // Fail path
        tbl.push_back(mk("fail_arm",   1, 0, 32'h000, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("fail_5dc",   0, 1, 32'h5DC, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("fail",       0, 1, 32'h5DC, 0, 0, 1, 0, 2, 32'h5DC));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Watchdog: 10 cycles with no match
        timeoutCycles = 32'd10;
        step(mk("to_arm", 1, 0, 32'h0, 1, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            step(mk($sformatf("to_cyc%0d", k), 0, 1, 32'h100 + 32'(k * 4),
                    (k < 10), 0, 0, (k == 10), 32'(k), 0));
        end
        step(mk("to_held", 0, 1, 32'h5F0, 0, 0, 0, 1, 10, 0));

        // Pass hit on the timeout cycle wins
        step(mk("tp_arm", 1, 0, 32'h0, 1, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            step(mk($sformatf("tp_cyc%0d", k), 0, 1, 32'h100, 1, 0, 0, 0, 32'(k), 0));
        end
        step(mk("tp_cyc9", 0, 1, 32'h5F0, 1, 0, 0, 0, 9, 0));
        step(mk("tp_pass", 0, 1, 32'h5F0, 0, 1, 0, 0, 10, 32'h5F0));

        // timeout_cycles = 1
        timeoutCycles = 32'd1;
        step(mk("to1_arm", 1, 0, 32'h0, 1, 0, 0, 0, 0, 0));
        step(mk("to1_tmo", 0, 1, 32'h100, 0, 0, 0, 1, 1, 0));
        timeoutCycles = 32'd0;

        // Priority: pass_pc == fail_pc, fail wins (HIT_N=1 instance completes on first match)
        passPc = 32'h200;
        failPc = 32'h200;
        step(mk("pri_arm", 1, 0, 32'h0, 1, 0, 0, 0, 0, 0));
        checkHit1("pri_h1_arm", 1, 0, 0, 0, 0);
        step(mk("pri_200a", 0, 1, 32'h200, 1, 0, 0, 0, 1, 0));
        checkHit1("pri_h1_fail", 0, 0, 1, 1, 32'h200);
        step(mk("pri_fail", 0, 1, 32'h200, 0, 0, 1, 0, 2, 32'h200));
        checkHit1("pri_h1_held", 0, 0, 1, 1, 32'h200);
        passPc = 32'h5F0;
        failPc = 32'h5DC;

        // Asynchronous reset mid-RUN
        step(mk("rst_arm", 1, 0, 32'h0, 1, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            step(mk($sformatf("rst_cyc%0d", k), 0, 1, 32'h5F0 + 32'(k & 1) * 4,
                    1, 0, 0, 0, 32'(k), 0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk("post_rst_idle", 0, 1, 32'h5F0, 0, 0, 0, 0, 0, 0));
        step(mk("post_rst_arm",  1, 0, 32'h0,   1, 0, 0, 0, 0, 0));

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/sim_status_monitor.md
Name: sim_status_monitor

Overview:
- Synthesizable pass/fail/timeout monitor for ISA self-check programs.
- Watches the IF/ID PC stream of Core and reports completion status, cycle count and final PC.
- Successor to the fixed-address testbench checker:
  - PC width, hit count and counter width are parametrised.
  - Pass/fail addresses and timeout are runtime inputs.
  - Adds consecutive-match qualification with stall tolerance, a watchdog timeout and re-arm.
- Sits beside Core in simulation and FPGA bring-up; outputs drive a log/LED/UART status path.

Parameters:
PC_W, 32, PC width in bits
CNT_W, 32, cycle-counter and timeout width
HIT_N, 2, consecutive valid matching PC samples required to declare pass or fail (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset
start  input  1  arm pulse; clears counters and enters RUN
pc_valid  input  1  pc is a real fetch/decode sample this cycle (low = stall/bubble)
pc  input  PC_W  IF/ID current PC
pass_pc  input  PC_W  pass-loop address; stable while in RUN
fail_pc  input  PC_W  fail-loop address; stable while in RUN
timeout_cycles  input  CNT_W  watchdog limit in RUN cycles; 0 disables
busy  output  1  state == RUN
done  output  1  state is PASS, FAIL or TIMEOUT
pass  output  1  state == PASS
fail  output  1  state == FAIL
timeout  output  1  state == TIMEOUT
cycle_count  output  CNT_W  cycles spent in RUN; frozen after completion
final_pc  output  PC_W  pc sampled on the completing cycle (0 for timeout)

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rst_n.
- Reset (async, any time, including mid-RUN):
  - State goes to IDLE.
  - All outputs are 0 and both hit counters are 0.
- States are IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered or decoded directly from registered state.
- IDLE: start=1 -> RUN at the next edge, with cycle_count, final_pc and hit counters cleared to 0.
- RUN, every edge:
  - cycle_count increments, saturating at all-ones.
  - The increment also occurs on the exiting edge, so the frozen value equals the number of RUN cycles.
  - start is ignored while in RUN.
- Hit counters (one for pass, one for fail), updated on each RUN edge:
  - pc_valid=1 and pc==target: counter increments, saturating at HIT_N.
  - pc_valid=1 and pc!=target: counter clears to 0.
  - pc_valid=0: counter holds (stalls do not break a streak).
- Completion is evaluated combinationally on the RUN cycle:
  - pass_hit = pc_valid & pc==pass_pc & pass_cnt==HIT_N-1.
  - fail_hit is formed the same way from fail_pc and fail_cnt.
- Transitions out of RUN, in priority order:
  - fail_hit -> FAIL.
  - else pass_hit -> PASS.
  - else timeout_cycles!=0 and cycle_count+1==timeout_cycles -> TIMEOUT.
- Simultaneous events:
  - Fail beats pass, including when pass_pc==fail_pc.
  - A pass or fail hit on the timeout cycle beats timeout.
- Latency and final_pc:
  - done asserts on the edge after the cycle carrying the HIT_N-th consecutive valid match.
  - final_pc latches pc on that same edge.
- timeout_cycles=1: TIMEOUT after exactly 1 RUN cycle unless a hit occurs on that cycle.
- HIT_N=1: the first valid match completes.
- Terminal states (PASS/FAIL/TIMEOUT):
  - Sticky, with outputs held.
  - start=1 re-arms: -> RUN with all counters and final_pc cleared.
- cycle_count arithmetic is unsigned CNT_W, with no wrap (saturation only).
- Comparisons are full-width equality on PC_W bits.

Decomposition:
- Package sim_mon_pkg holds:
  - The state enum (IDLE, RUN, PASS, FAIL, TIMEOUT; 3-bit).
  - Default width constants.
- Sub-module target_matcher (params PC_W, HIT_N):
  - Inputs: clk, rst_n, clr, en, pc_valid, pc, target.
  - Outputs: hit (combinational completion) and cnt.
  - Instantiated twice, once for pass and once for fail.
- The top level holds the FSM, cycle counter and final_pc register.

Test Plan:
- Basic pass:
  - Stimulus: HIT_N=2, pass_pc=0x5F0, fail_pc=0x5DC, timeout=0, start; valid pc 0x100,0x104,0x5F0,0x5F0.
  - Response: pass=1, done=1 one edge after the second 0x5F0; final_pc=0x5F0; cycle_count=4.
- Stall tolerance and streak break:
  - Stimulus: valid 0x5F0, invalid, valid 0x5F0.
  - Response: pass after the third cycle.
  - Stimulus, separately: 0x5F0, 0x5F4, 0x5F0.
  - Response: no pass until a further consecutive 0x5F0.
- Timeout:
  - Stimulus: timeout_cycles=10; pc never matches.
  - Response: timeout=1 after 10 RUN cycles; cycle_count=10; final_pc=0.
  - Stimulus: hit on the 10th cycle.
  - Response: PASS, not TIMEOUT.
- Priority:
  - Stimulus: pass_pc=fail_pc=0x200, HIT_N=1, valid pc 0x200.
  - Response: fail=1, pass=0.
- Reset and re-arm:
  - Stimulus: rst_n low mid-RUN (cycle 5).
  - Response: all outputs 0 immediately (asynchronously); IDLE.
  - Stimulus: after PASS, pulse start.
  - Response: busy=1, cycle_count=0, pass=0; the run repeats identically.
